df_tap_pair_sum: RTL and testbench



---
 rtl/df_pkg.sv | 20 ++
 rtl/df_tap_shreg.sv | 31 +++
 rtl/df_tap_pair_sum.sv | 110 +++++++++++
 tb/tb_df_tap_pair_sum.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/df_pkg.sv
// Shared definitions for the moving-average datapath: sample/operand widths,
// delay-line depth and the fill-phase encoding.
package df_pkg;

  localparam int SAMPLE_W  = 8;
  localparam int OPERAND_W = SAMPLE_W + 1;
  localparam int TAPS      = 4;

  typedef enum logic {
    PH_FILL = 1'b0,
    PH_RUN  = 1'b1
  } fill_phase_e;

  // Zero-extended pair sum; the carry lands in the extra bit, so it never wraps.
  function automatic logic [OPERAND_W-1:0] pair_add(input logic [SAMPLE_W-1:0] a,
                                                     input logic [SAMPLE_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/df_tap_shreg.sv
// Parameterised delay line: taps[0] is the newest sample, taps[DEPTH-1] the oldest.
module df_tap_shreg #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      shift_en,
  input  logic [W-1:0]              d,
  output logic [DEPTH-1:0][W-1:0]   taps
);

  logic [DEPTH-1:0][W-1:0] taps_r;

  // Shift on enable, synchronous clear has priority over shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps_r <= '0;
    end else if (clr) begin
      taps_r <= '0;
    end else if (shift_en) begin
      taps_r <= {taps_r[DEPTH-2:0], d};
    end else begin
      taps_r <= taps_r;
    end
  end

  assign taps = taps_r;

endmodule

// File: rtl/df_tap_pair_sum.sv
// Moving-average front end: 4-tap delay line feeding two registered pair sums
// behind a single-entry valid/ready output stage.
module df_tap_pair_sum
  import df_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [SAMPLE_W-1:0]   in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [OPERAND_W-1:0]  out_a,
  output logic [OPERAND_W-1:0]  out_b,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam logic [2:0] FILL_FULL = 3'(TAPS);

  logic [TAPS-1:0][SAMPLE_W-1:0] taps_s;
  logic                          in_ready_s;
  logic                          acc_s;
  logic [2:0]                    fill_cnt_r;
  logic [2:0]                    fill_nxt_s;
  fill_phase_e                   phase_nxt_s;
  logic [OPERAND_W-1:0]          sum_a_s;
  logic [OPERAND_W-1:0]          sum_b_s;
  logic [OPERAND_W-1:0]          out_a_r;
  logic [OPERAND_W-1:0]          out_b_r;
  logic                          out_valid_r;
  logic                          x3_unused_s;

  df_tap_shreg #(
    .W     (SAMPLE_W),
    .DEPTH (TAPS)
  ) u_shreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .shift_en (acc_s),
    .d        (in_data),
    .taps     (taps_s)
  );

  // The oldest tap completes the delay line but is not an operand of either sum.
  assign x3_unused_s = ^taps_s[TAPS-1];

  assign in_ready_s = !flush && (!out_valid_r || out_ready);
  assign acc_s      = in_valid && in_ready_s;

  // Sums use the post-shift view: x[n]=in_data, x[n-1..n-3]=taps[0..2] before the edge.
  always_comb begin
    sum_a_s = pair_add(in_data, taps_s[0]);
    sum_b_s = pair_add(taps_s[1], taps_s[2]);
    if (fill_cnt_r == FILL_FULL) begin
      fill_nxt_s = fill_cnt_r;
    end else begin
      fill_nxt_s = fill_cnt_r + 3'd1;
    end
    if (fill_nxt_s == FILL_FULL) begin
      phase_nxt_s = PH_RUN;
    end else begin
      phase_nxt_s = PH_FILL;
    end
  end

  // Fill counter saturates once the delay line holds a full set of real samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt_r <= 3'd0;
    end else if (flush) begin
      fill_cnt_r <= 3'd0;
    end else if (acc_s) begin
      fill_cnt_r <= fill_nxt_s;
    end else begin
      fill_cnt_r <= fill_cnt_r;
    end
  end

  // Output stage: a new result replaces the old one even while it drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_a_r     <= '0;
      out_b_r     <= '0;
      out_valid_r <= 1'b0;
    end else if (flush) begin
      out_a_r     <= '0;
      out_b_r     <= '0;
      out_valid_r <= 1'b0;
    end else if (acc_s) begin
      out_a_r     <= sum_a_s;
      out_b_r     <= sum_b_s;
      out_valid_r <= (phase_nxt_s == PH_RUN);
    end else if (out_valid_r && out_ready) begin
      out_a_r     <= out_a_r;
      out_b_r     <= out_b_r;
      out_valid_r <= 1'b0;
    end else begin
      out_a_r     <= out_a_r;
      out_b_r     <= out_b_r;
      out_valid_r <= out_valid_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_a     = out_a_r;
  assign out_b     = out_b_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_df_tap_pair_sum.sv
// Self-checking bench for df_tap_pair_sum: directed scenarios plus random
// traffic against a sample-history reference model.
module tb_df_tap_pair_sum;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [8:0] out_a;
  logic [8:0] out_b;
  logic       out_valid;
  logic       out_ready = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: accepted samples since reset/flush, newest first, plus the pending result.
  int hist[$];
  bit exp_v = 1'b0;
  int exp_a = 0;
  int exp_b = 0;

  df_tap_pair_sum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    exp_v = 1'b0;
    exp_a = 0;
    exp_b = 0;
  endtask

  // One clock cycle: drive, check in_ready, advance the model, then check outputs after the edge.
  task automatic step(input bit v, input int d, input bit r, input bit f);
    bit rdy;
    in_valid  = v;
    in_data   = d[7:0];
    out_ready = r;
    flush     = f;
    #1;
    rdy = !f && (!exp_v || r);
    check_eq("in_ready", int'(in_ready), int'(rdy));
    if (f) begin
      model_reset();
    end else if (v && rdy) begin
      hist.push_front(d & 255);
      if (hist.size() > 4) void'(hist.pop_back());
      if (hist.size() == 4) begin
        exp_v = 1'b1;
        exp_a = hist[0] + hist[1];
        exp_b = hist[2] + hist[3];
      end else begin
        exp_v = 1'b0;
      end
    end else if (exp_v && r) begin
      exp_v = 1'b0;
    end
    @(posedge clk);
    #1;
    check_eq("out_valid", int'(out_valid), int'(exp_v));
    if (exp_v) begin
      check_eq("out_a", int'(out_a), exp_a);
      check_eq("out_b", int'(out_b), exp_b);
    end
  endtask

  initial begin
    #12;
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_out_a", int'(out_a), 0);
    check_eq("rst_out_b", int'(out_b), 0);
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    model_reset();

    // Fill with 10, 20, 30, 40.
    for (int i = 1; i <= 4; i++) step(1'b1, 10 * i, 1'b1, 1'b0);
    check_eq("fill_a70", int'(out_a), 70);
    check_eq("fill_b30", int'(out_b), 30);

    // Max range without wrap.
    for (int i = 0; i < 4; i++) step(1'b1, 255, 1'b1, 1'b0);
    check_eq("max_a510", int'(out_a), 510);
    check_eq("max_b510", int'(out_b), 510);

    // Backpressure: three stalled cycles, then accept on release.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 7 + i, 1'b0, 1'b0);
      check_eq("bp_hold_a", int'(out_a), 510);
    end
    step(1'b1, 1, 1'b1, 1'b0);
    check_eq("bp_release_a", int'(out_a), 256);

    // Streaming 1,2,3,... from a fresh fill.
    step(1'b0, 0, 1'b1, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      step(1'b1, k, 1'b1, 1'b0);
      if (k >= 4) begin
        check_eq("stream_a", int'(out_a), 2 * k - 1);
        check_eq("stream_b", int'(out_b), 2 * k - 5);
      end
    end

    // Flush while a result is pending: 99 must be dropped.
    step(1'b1, 12, 1'b0, 1'b0);
    step(1'b1, 99, 1'b0, 1'b1);
    check_eq("flush_valid", int'(out_valid), 0);
    for (int i = 0; i < 4; i++) step(1'b1, 5, 1'b1, 1'b0);
    check_eq("flush_a10", int'(out_a), 10);
    check_eq("flush_b10", int'(out_b), 10);

    // Asynchronous reset between edges.
    step(1'b1, 200, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", int'(out_valid), 0);
    check_eq("arst_a", int'(out_a), 0);
    check_eq("arst_b", int'(out_b), 0);
    model_reset();
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(1'b1, 60 + i, 1'b1, 1'b0);
    check_eq("arst_refill", int'(out_valid), 0);
    step(1'b1, 63, 1'b1, 1'b0);
    check_eq("arst_refill_a", int'(out_a), 125);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
           $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
